// File: rtl/spi_burst_ctrl_if.sv
// Command, byte-stream and SPI peripheral register-port bundle
// for the SPI burst sequencer.
interface spi_burst_ctrl_if #(
    parameter int LEN_W = 8
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [LEN_W-1:0] cmd_len;
    logic [15:0]      cmd_ss;
    logic [7:0]       tx_data;
    logic             tx_valid;
    logic             tx_ready;
    logic [7:0]       rx_data;
    logic             rx_valid;
    logic             rx_ready;
    logic             done;
    logic             err;
    logic             spi_select;
    logic [2:0]       spi_addr;
    logic             spi_read_n;
    logic             spi_write_n;
    logic [15:0]      spi_wdata;
    logic [15:0]      spi_rdata;
    logic             spi_readyfordata;
    logic             spi_dataavailable;

    modport master (
        input  cmd_valid, cmd_len, cmd_ss,
        input  tx_data, tx_valid, rx_ready,
        input  spi_rdata, spi_readyfordata, spi_dataavailable,
        output cmd_ready, tx_ready, rx_data, rx_valid,
        output done, err,
        output spi_select, spi_addr, spi_read_n, spi_write_n,
        output spi_wdata
    );

    modport slave (
        output cmd_valid, cmd_len, cmd_ss,
        output tx_data, tx_valid, rx_ready,
        output spi_rdata, spi_readyfordata, spi_dataavailable,
        input  cmd_ready, tx_ready, rx_data, rx_valid,
        input  done, err,
        input  spi_select, spi_addr, spi_read_n, spi_write_n,
        input  spi_wdata
    );
endinterface

// File: rtl/spi_burst_ctrl.sv
// Burst sequencer for the SPI master peripheral: slave select,
// byte streaming with one byte in flight, per-byte watchdog.
module spi_burst_ctrl #(
    parameter int LEN_W   = 8,
    parameter int TIMEOUT = 1023,
    parameter int TO_W    = 10
) (
    input logic              clk,
    input logic              reset_n,
    spi_burst_ctrl_if.master bus
);
    localparam logic [3:0] IDLE    = 4'd0;
    localparam logic [3:0] SS_WR   = 4'd1;
    localparam logic [3:0] CTL_ON  = 4'd2;
    localparam logic [3:0] WAIT_TX = 4'd3;
    localparam logic [3:0] DATA_WR = 4'd4;
    localparam logic [3:0] WAIT_RX = 4'd5;
    localparam logic [3:0] DATA_RD = 4'd6;
    localparam logic [3:0] RX_HOLD = 4'd7;
    localparam logic [3:0] CTL_OFF = 4'd8;
    localparam logic [3:0] ABORT   = 4'd9;
    localparam logic [3:0] DONE    = 4'd10;

    localparam logic [TO_W-1:0] WD_LAST = TO_W'(TIMEOUT - 1);

    logic [3:0]       state;
    logic [1:0]       ph;
    logic [LEN_W-1:0] cnt;
    logic [TO_W-1:0]  wd;
    logic             abort_q;
    logic [15:0]      ss_q;
    logic [7:0]       tx_byte;
    logic [7:0]       rx_byte;

    logic bus_st, sel, bus_end, tx_fire;

    // Bus states run phase A (0), phase B (1), then one idle gap (2).
    assign bus_st  = (state == SS_WR)   || (state == CTL_ON)  ||
                     (state == DATA_WR) || (state == DATA_RD) ||
                     (state == CTL_OFF) || (state == ABORT);
    assign sel     = bus_st && (ph != 2'd2);
    assign bus_end = bus_st && (ph == 2'd2);
    assign tx_fire = (state == WAIT_TX) && bus.spi_readyfordata
                     && bus.tx_valid;

    assign bus.cmd_ready  = (state == IDLE);
    assign bus.tx_ready   = tx_fire;
    assign bus.rx_valid   = (state == RX_HOLD);
    assign bus.rx_data    = rx_byte;
    assign bus.done       = (state == DONE);
    assign bus.err        = (state == DONE) && abort_q;
    assign bus.spi_select = sel;

    always_comb begin
        bus.spi_addr    = 3'd0;
        bus.spi_wdata   = 16'h0000;
        bus.spi_read_n  = 1'b1;
        bus.spi_write_n = 1'b1;
        if (sel) begin
            bus.spi_write_n = (state == DATA_RD);
            bus.spi_read_n  = (state != DATA_RD);
            case (state)
                SS_WR: begin
                    bus.spi_addr  = 3'd5;
                    bus.spi_wdata = ss_q;
                end
                CTL_ON: begin
                    bus.spi_addr  = 3'd3;
                    bus.spi_wdata = 16'h0400;
                end
                DATA_WR: begin
                    bus.spi_addr  = 3'd1;
                    bus.spi_wdata = {8'h00, tx_byte};
                end
                CTL_OFF: bus.spi_addr = 3'd3;
                ABORT:   bus.spi_addr = 3'd2;
                default: bus.spi_addr = 3'd0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            ph      <= 2'd0;
            cnt     <= '0;
            wd      <= '0;
            abort_q <= 1'b0;
            ss_q    <= 16'h0000;
            tx_byte <= 8'h00;
            rx_byte <= 8'h00;
        end else begin
            ph <= (bus_st && !bus_end) ? ph + 2'd1 : 2'd0;
            case (state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        cnt     <= bus.cmd_len;
                        ss_q    <= bus.cmd_ss;
                        abort_q <= 1'b0;
                        state   <= (bus.cmd_len == '0) ? DONE : SS_WR;
                    end
                end
                SS_WR:   if (bus_end) state <= CTL_ON;
                CTL_ON:  if (bus_end) state <= WAIT_TX;
                WAIT_TX: begin
                    // A starved upstream is not a peripheral stall.
                    if (tx_fire) begin
                        tx_byte <= bus.tx_data;
                        wd      <= '0;
                        state   <= DATA_WR;
                    end else if (bus.tx_valid && !bus.spi_readyfordata) begin
                        if (wd == WD_LAST) begin
                            abort_q <= 1'b1;
                            wd      <= '0;
                            state   <= ABORT;
                        end else begin
                            wd <= wd + TO_W'(1);
                        end
                    end
                end
                DATA_WR: if (bus_end) state <= WAIT_RX;
                WAIT_RX: begin
                    if (bus.spi_dataavailable) begin
                        wd    <= '0;
                        state <= DATA_RD;
                    end else if (wd == WD_LAST) begin
                        abort_q <= 1'b1;
                        wd      <= '0;
                        state   <= ABORT;
                    end else begin
                        wd <= wd + TO_W'(1);
                    end
                end
                DATA_RD: begin
                    if (ph == 2'd1) rx_byte <= bus.spi_rdata[7:0];
                    if (bus_end) state <= RX_HOLD;
                end
                RX_HOLD: begin
                    if (bus.rx_ready) begin
                        cnt   <= cnt - LEN_W'(1);
                        state <= (cnt == LEN_W'(1)) ? CTL_OFF : WAIT_TX;
                    end
                end
                CTL_OFF: if (bus_end) state <= DONE;
                ABORT:   if (bus_end) state <= CTL_OFF;
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_burst_ctrl.sv
// Directed bench for spi_burst_ctrl with a loopback peripheral
// model and a register-access log.
module tb_spi_burst_ctrl;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    spi_burst_ctrl_if #(.LEN_W(8)) bus ();

    spi_burst_ctrl dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    logic [20:0] acc_q[$];
    int          acc_t[$];
    logic [7:0]  rx_q[$];
    logic [7:0]  tx_q[$];
    int          tx_idx;
    logic        tx_en;
    logic        tx_fire_q;
    logic        sel_q;
    int          hi_len;
    logic [20:0] cur;
    logic        avail_en;
    logic [7:0]  loop_byte;
    int          done_cnt;
    int          err_cnt;
    logic        done_q;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [20:0] acc(input logic rd, input logic wr,
                                        input logic [2:0] a,
                                        input logic [15:0] d);
        return {rd, wr, a, d};
    endfunction

    assign bus.spi_rdata = {8'h00, loop_byte};

    always @(posedge clk) cyc++;

    // Access log, select-width check, loopback model, rx/tx/done tracking
    always @(negedge clk) begin
        if (!reset_n) begin
            sel_q     = 1'b0;
            hi_len    = 0;
            done_q    = 1'b0;
            tx_fire_q = 1'b0;
        end else begin
            if (bus.spi_select) begin
                if (!sel_q) begin
                    cur = {~bus.spi_read_n, ~bus.spi_write_n,
                           bus.spi_addr, bus.spi_wdata};
                    acc_q.push_back(cur);
                    acc_t.push_back(cyc);
                    hi_len = 0;
                end
                hi_len++;
            end else if (sel_q) begin
                check("sel_len", hi_len, 2);
                if (cur[19] && cur[18:16] == 3'd1) begin
                    loop_byte = cur[7:0];
                    bus.spi_dataavailable = avail_en;
                end
                if (cur[20] && cur[18:16] == 3'd0)
                    bus.spi_dataavailable = 1'b0;
            end
            sel_q = bus.spi_select;
            if (bus.rx_valid && bus.rx_ready) rx_q.push_back(bus.rx_data);
            if (bus.done) begin
                done_cnt++;
                if (bus.err) err_cnt++;
                check("done_1cyc", done_q, 0);
            end
            done_q = bus.done;
            if (tx_fire_q) tx_idx++;
            tx_fire_q = bus.tx_ready;
        end
        bus.tx_valid = tx_en && (tx_idx < tx_q.size());
        bus.tx_data  = bus.tx_valid ? tx_q[tx_idx] : 8'h00;
    end

    task automatic clear_logs();
        acc_q.delete();
        acc_t.delete();
        rx_q.delete();
        tx_idx   = 0;
        done_cnt = 0;
        err_cnt  = 0;
    endtask

    task automatic send_cmd(input logic [7:0] len, input logic [15:0] ss);
        @(negedge clk);
        check("cmd_ready", bus.cmd_ready, 1);
        bus.cmd_valid = 1'b1;
        bus.cmd_len   = len;
        bus.cmd_ss    = ss;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        bus.cmd_len   = 8'h00;
        bus.cmd_ss    = 16'h0000;
    endtask

    task automatic wait_done(input int bound);
        int start;
        int n;
        start = done_cnt;
        n = 0;
        while (done_cnt == start && n < bound) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("done_seen", (done_cnt != start), 1);
    endtask

    task automatic check_reset_outs(input string tag);
        check({tag, "_ctl"},
              {bus.cmd_ready, bus.tx_ready, bus.rx_valid, bus.done,
               bus.err, bus.spi_select, bus.spi_read_n, bus.spi_write_n},
              8'b1000_0011);
        check({tag, "_bus"}, {bus.spi_addr, bus.spi_wdata, bus.rx_data}, 0);
    endtask

    initial begin
        int n;
        int bad;
        logic [7:0] d0;
        int n0;

        bus.cmd_valid         = 1'b0;
        bus.cmd_len           = 8'h00;
        bus.cmd_ss            = 16'h0000;
        bus.rx_ready          = 1'b1;
        bus.spi_readyfordata  = 1'b1;
        bus.spi_dataavailable = 1'b0;
        bus.tx_valid          = 1'b0;
        bus.tx_data           = 8'h00;
        avail_en  = 1'b1;
        loop_byte = 8'h00;
        tx_en     = 1'b1;
        clear_logs();

        repeat (3) @(negedge clk);
        check_reset_outs("rst_init");
        reset_n = 1'b1;

        // Reset asserted in the middle of a data write
        tx_q = '{8'h11, 8'h22};
        send_cmd(8'd2, 16'h0002);
        n = 0;
        while (!(bus.spi_select && bus.spi_addr == 3'd1 && !bus.spi_write_n)
               && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("rst_reach_dwr", (n < 200), 1);
        reset_n = 1'b0;
        #1;
        check_reset_outs("rst_mid");
        @(negedge clk);
        bus.spi_dataavailable = 1'b0;
        reset_n = 1'b1;
        clear_logs();

        // Three-byte loopback burst
        tx_q = '{8'hA5, 8'h3C, 8'hFF};
        send_cmd(8'd3, 16'h0001);
        wait_done(500);
        check("b3_nacc", acc_q.size(), 9);
        if (acc_q.size() == 9) begin
            check("b3_ss",   acc_q[0], acc(0, 1, 3'd5, 16'h0001));
            check("b3_on",   acc_q[1], acc(0, 1, 3'd3, 16'h0400));
            check("b3_w0",   acc_q[2], acc(0, 1, 3'd1, 16'h00A5));
            check("b3_r0",   acc_q[3], acc(1, 0, 3'd0, 16'h0000));
            check("b3_w1",   acc_q[4], acc(0, 1, 3'd1, 16'h003C));
            check("b3_r1",   acc_q[5], acc(1, 0, 3'd0, 16'h0000));
            check("b3_w2",   acc_q[6], acc(0, 1, 3'd1, 16'h00FF));
            check("b3_r2",   acc_q[7], acc(1, 0, 3'd0, 16'h0000));
            check("b3_off",  acc_q[8], acc(0, 1, 3'd3, 16'h0000));
            check("b3_gap",  acc_t[1] - acc_t[0], 3);
        end
        check("b3_nrx", rx_q.size(), 3);
        if (rx_q.size() == 3)
            check("b3_rx", {rx_q[0], rx_q[1], rx_q[2]}, 24'hA53CFF);
        check("b3_err", err_cnt, 0);
        check("b3_ndone", done_cnt, 1);
        clear_logs();

        // Downstream backpressure holds the received byte
        tx_q = '{8'h5A, 8'hC3};
        bus.rx_ready = 1'b0;
        send_cmd(8'd2, 16'h0004);
        n = 0;
        while (!bus.rx_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("bp_reach", (n < 200), 1);
        n0  = acc_q.size();
        d0  = bus.rx_data;
        bad = 0;
        repeat (50) begin
            @(negedge clk);
            if (!bus.rx_valid || bus.rx_data !== d0) bad++;
        end
        check("bp_hold", bad, 0);
        check("bp_data", d0, 8'h5A);
        check("bp_noacc", acc_q.size(), n0);
        bus.rx_ready = 1'b1;
        wait_done(500);
        check("bp_nacc", acc_q.size(), 7);
        check("bp_nrx", rx_q.size(), 2);
        if (rx_q.size() == 2)
            check("bp_rx", {rx_q[0], rx_q[1]}, 16'h5AC3);
        check("bp_err", err_cnt, 0);
        clear_logs();

        // Peripheral never reports data: watchdog abort
        avail_en = 1'b0;
        tx_q = '{8'h77};
        send_cmd(8'd1, 16'h0008);
        wait_done(1500);
        check("wd_nacc", acc_q.size(), 5);
        if (acc_q.size() == 5) begin
            check("wd_clr",  acc_q[3], acc(0, 1, 3'd2, 16'h0000));
            check("wd_off",  acc_q[4], acc(0, 1, 3'd3, 16'h0000));
            check("wd_time", acc_t[3] - acc_t[2], 1026);
        end
        check("wd_err", err_cnt, 1);
        avail_en = 1'b1;
        clear_logs();

        // Zero-length command
        send_cmd(8'd0, 16'h0001);
        check("z_done", {bus.done, bus.err}, 2'b10);
        @(negedge clk);
        check("z_done_off", bus.done, 0);
        check("z_nacc", acc_q.size(), 0);
        clear_logs();

        // Upstream starvation is not an error
        tx_en = 1'b0;
        tx_q = '{8'hE1};
        send_cmd(8'd1, 16'h0001);
        repeat (500) @(negedge clk);
        check("st_idle", {bus.done, bus.tx_ready, bus.cmd_ready}, 0);
        tx_en = 1'b1;
        wait_done(500);
        check("st_err", err_cnt, 0);
        check("st_nrx", rx_q.size(), 1);
        if (rx_q.size() == 1) check("st_rx", rx_q[0], 8'hE1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
